// File: rtl/seg7_dec_controller.sv
// seg7_dec_controller
// Converts a 7-bit binary count into two active-low 7-segment digits.
// A shared serial restoring divide-by-10 datapath runs under a start/busy/done
// handshake. A conversion starts when the value changes, on an explicit
// request, or when a request arrived while busy. Segment codes are only
// committed in a single WRITE cycle, so a partially converted digit is never
// visible on the outputs.
module seg7_dec_controller #(
  parameter bit          BLANK_LZ  = 1'b0,
  parameter int unsigned OVF_LIMIT = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] value,
  input  logic       conv_req,
  output logic [7:0] seg_tens,
  output logic [7:0] seg_ones,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Tens digit shown at reset: a "0", or blank when leading zeros are hidden.
  localparam logic [7:0] RST_TENS = BLANK_LZ ? 8'hFF : 8'hC0;

  state_t     state_r;
  logic [6:0] operand_r;
  logic [6:0] last_conv_r;
  logic [6:0] quot_r;
  logic [3:0] rem_r;
  logic [2:0] bitcnt_r;
  logic       pending_r;

  logic       start_s;
  logic [4:0] trial_s;
  logic [4:0] diff_s;
  logic       qbit_s;
  logic [3:0] rem_next_s;
  logic       ovf_s;
  logic [7:0] tens_code_s;
  logic [7:0] ones_code_s;

  // Active-low segment pattern for one decimal digit; dp (bit 7) stays off.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Start request: new value, explicit pulse, or a request remembered while busy.
  always_comb begin
    start_s = (value != last_conv_r) || conv_req || pending_r;
  end

  // One restoring-division step: shift in the next operand bit, subtract 10 if it fits.
  always_comb begin
    trial_s = {rem_r, operand_r[bitcnt_r]};
    diff_s  = trial_s - 5'd10;
    if (trial_s >= 5'd10) begin
      qbit_s     = 1'b1;
      rem_next_s = diff_s[3:0];
    end else begin
      qbit_s     = 1'b0;
      rem_next_s = trial_s[3:0];
    end
  end

  // Segment codes to commit once the quotient and remainder are final.
  always_comb begin
    ovf_s = ({25'd0, operand_r} > OVF_LIMIT);
    if (ovf_s) begin
      tens_code_s = 8'hBF;
      ones_code_s = 8'hBF;
    end else if (BLANK_LZ && (quot_r == 7'd0)) begin
      tens_code_s = 8'hFF;
      ones_code_s = seg_decode(rem_r);
    end else begin
      tens_code_s = seg_decode(quot_r[3:0]);
      ones_code_s = seg_decode(rem_r);
    end
  end

  // Conversion sequencer with registered handshake and display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      operand_r   <= 7'd0;
      last_conv_r <= 7'd0;
      quot_r      <= 7'd0;
      rem_r       <= 4'd0;
      bitcnt_r    <= 3'd0;
      pending_r   <= 1'b0;
      seg_tens    <= RST_TENS;
      seg_ones    <= 8'hC0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            operand_r   <= value;
            last_conv_r <= value;
            quot_r      <= 7'd0;
            rem_r       <= 4'd0;
            bitcnt_r    <= 3'd6;
            pending_r   <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (conv_req) begin
            pending_r <= 1'b1;
          end
          rem_r  <= rem_next_s;
          quot_r <= {quot_r[5:0], qbit_s};
          if (bitcnt_r == 3'd0) begin
            state_r <= ST_WRITE;
          end else begin
            bitcnt_r <= bitcnt_r - 3'd1;
          end
        end
        ST_WRITE: begin
          if (conv_req) begin
            pending_r <= 1'b1;
          end
          seg_tens <= tens_code_s;
          seg_ones <= ones_code_s;
          ovf      <= ovf_s;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_dec_controller.sv
// Self-checking bench for seg7_dec_controller: two instances (leading zero
// shown / blanked) share stimulus and are compared against a decimal model.
module tb_seg7_dec_controller;

  logic       clk;
  logic       rst;
  logic [6:0] value;
  logic       conv_req;
  logic [7:0] seg_tens, seg_ones, seg_tens_b, seg_ones_b;
  logic       busy, done, ovf, busy_b, done_b, ovf_b;

  int vecs;
  int miscompares;
  int done_cnt;
  int last_v;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg7_dec_controller #(.BLANK_LZ(1'b0), .OVF_LIMIT(99)) dut (
    .clk(clk), .rst(rst), .value(value), .conv_req(conv_req),
    .seg_tens(seg_tens), .seg_ones(seg_ones), .busy(busy), .done(done), .ovf(ovf)
  );

  seg7_dec_controller #(.BLANK_LZ(1'b1), .OVF_LIMIT(99)) dut_b (
    .clk(clk), .rst(rst), .value(value), .conv_req(conv_req),
    .seg_tens(seg_tens_b), .seg_ones(seg_ones_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference model.
  function automatic logic [7:0] exp_tens(input int v, input bit blank);
    if (v > 99) return 8'hBF;
    if (blank && (v / 10 == 0)) return 8'hFF;
    return seg_tab[v / 10];
  endfunction

  function automatic logic [7:0] exp_ones(input int v);
    if (v > 99) return 8'hBF;
    return seg_tab[v % 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full conversion from IDLE with latency and output checks.
  task automatic run_conv(input int v);
    value    = 7'(v);
    conv_req = (v == last_v);
    for (int i = 0; i < 8; i++) begin
      tick();
      conv_req = 1'b0;
      vecs++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_phase v=%0d cyc=%0d busy=%b done=%b required busy=1 done=0", v, i, busy, done);
      end
    end
    tick();
    vecs++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_edge v=%0d busy=%b done=%b required busy=0 done=1", v, busy, done);
    end
    vecs++;
    if (seg_tens !== exp_tens(v, 1'b0) || seg_ones !== exp_ones(v) || ovf !== (v > 99)) begin
      miscompares++;
      $display("FAIL digits v=%0d got %h/%h ovf=%b required %h/%h ovf=%b", v, seg_tens, seg_ones, ovf,
               exp_tens(v, 1'b0), exp_ones(v), (v > 99));
    end
    vecs++;
    if (seg_tens_b !== exp_tens(v, 1'b1) || seg_ones_b !== exp_ones(v)) begin
      miscompares++;
      $display("FAIL digits_blank v=%0d got %h/%h required %h/%h", v, seg_tens_b, seg_ones_b,
               exp_tens(v, 1'b1), exp_ones(v));
    end
    last_v = v;
    tick();
    vecs++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width v=%0d done=%b required 0", v, done);
    end
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b0; value = 7'd0; conv_req = 1'b0;
    repeat (3) tick();
    vecs++;
    if (seg_tens !== 8'hC0 || seg_ones !== 8'hC0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got %h/%h b=%b d=%b o=%b required C0/C0 0 0 0", seg_tens, seg_ones, busy, done, ovf);
    end
    vecs++;
    if (seg_tens_b !== 8'hFF || seg_ones_b !== 8'hC0) begin
      miscompares++;
      $display("FAIL reset_blank got %h/%h required FF/C0", seg_tens_b, seg_ones_b);
    end
    rst = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      vecs++;
      if (busy !== 1'b0 || seg_tens !== 8'hC0 || seg_ones !== 8'hC0) begin
        miscompares++;
        $display("FAIL idle_hold cyc=%0d busy=%b segs=%h/%h required 0 C0/C0", i, busy, seg_tens, seg_ones);
      end
    end
    vecs++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL idle_no_done got %0d pulses required 0", done_cnt - d0);
    end
    last_v = 0;
  endtask

  task automatic test_basic();
    run_conv(57);
    run_conv(100);
    run_conv(127);
    run_conv(99);
    run_conv(7);
    run_conv(0);
    run_conv(0);
  endtask

  task automatic test_value_while_busy();
    int d0;
    bit ok;
    d0 = done_cnt;
    value = 7'd12;
    repeat (4) tick();
    value = 7'd34;
    tick();
    value = 7'd56;
    wait_done(ok);
    vecs++;
    if (!ok || seg_tens !== 8'hF9 || seg_ones !== 8'hA4) begin
      miscompares++;
      $display("FAIL busy_first ok=%b got %h/%h required F9/A4", ok, seg_tens, seg_ones);
    end
    wait_done(ok);
    vecs++;
    if (!ok || seg_tens !== 8'h92 || seg_ones !== 8'h82) begin
      miscompares++;
      $display("FAIL busy_second ok=%b got %h/%h required 92/82", ok, seg_tens, seg_ones);
    end
    repeat (15) tick();
    vecs++;
    if (done_cnt - d0 != 2) begin
      miscompares++;
      $display("FAIL busy_done_count got %0d required 2", done_cnt - d0);
    end
    last_v = 56;
  endtask

  task automatic test_req_and_change();
    int d0;
    d0 = done_cnt;
    value = 7'd81;
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    repeat (20) tick();
    vecs++;
    if (done_cnt - d0 != 1 || seg_tens !== 8'h80 || seg_ones !== 8'hF9) begin
      miscompares++;
      $display("FAIL req_with_change pulses=%0d got %h/%h required 1 80/F9", done_cnt - d0, seg_tens, seg_ones);
    end
    last_v = 81;
  endtask

  task automatic test_back_to_back_and_abort();
    int d0;
    bit ok;
    run_conv(42);
    d0 = done_cnt;
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    tick();
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    tick();
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    wait_done(ok);
    vecs++;
    if (!ok || seg_tens !== 8'h99 || seg_ones !== 8'hA4) begin
      miscompares++;
      $display("FAIL req_first ok=%b got %h/%h required 99/A4", ok, seg_tens, seg_ones);
    end
    tick();
    vecs++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back busy=%b required 1", busy);
    end
    wait_done(ok);
    vecs++;
    if (!ok || seg_tens !== 8'h99 || seg_ones !== 8'hA4) begin
      miscompares++;
      $display("FAIL req_extra ok=%b got %h/%h required 99/A4", ok, seg_tens, seg_ones);
    end
    repeat (15) tick();
    vecs++;
    if (done_cnt - d0 != 2) begin
      miscompares++;
      $display("FAIL req_collapse got %0d pulses required 2", done_cnt - d0);
    end
    d0 = done_cnt;
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    vecs++;
    if (seg_tens !== 8'hC0 || seg_ones !== 8'hC0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state got %h/%h busy=%b done=%b ovf=%b required C0/C0 0 0 0", seg_tens, seg_ones, busy, done, ovf);
    end
    repeat (10) tick();
    vecs++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d pulses required 0", done_cnt - d0);
    end
    rst = 1'b1;
    wait_done(ok);
    vecs++;
    if (!ok || seg_tens !== 8'h99 || seg_ones !== 8'hA4) begin
      miscompares++;
      $display("FAIL post_reset_reconv ok=%b got %h/%h required 99/A4", ok, seg_tens, seg_ones);
    end
    tick();
    last_v = 42;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_conv(int'($urandom_range(0, 127)));
    end
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    done_cnt = 0;
    last_v = 0;
    test_reset();
    test_basic();
    test_value_while_busy();
    test_req_and_change();
    test_back_to_back_and_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_dec_controller.md
Name: seg7_dec_controller

Overview:
- Sequences a shared serial restoring divide-by-10 datapath that converts a 7-bit binary count into tens and ones decimal digits.
- Drives two active-low 7-segment digit buses (LED7SEG1 = tens, LED7SEG2 = ones) from the top level.
- Replaces a free-running divider core with a controller that has an explicit start/busy/done handshake.
- Reconverts automatically whenever the input value changes; also reconverts on an explicit request.

Parameters:
- BLANK_LZ, 0: when 1, a tens digit of 0 displays as blank (8'hFF) instead of "0".
- OVF_LIMIT, 99: largest value that is displayed; any value above it shows as overflow.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- value  in  7  binary count to display; sampled only in IDLE
- conv_req  in  1  single-cycle pulse that forces a reconversion even if value is unchanged
- seg_tens  out  8  tens digit segments, active-low, bit7 = dp (always 1)
- seg_ones  out  8  ones digit segments, active-low
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new segment codes are committed
- ovf  out  1  high while the displayed value is greater than OVF_LIMIT

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; last_conv=0; pending=0.
  - seg_tens=8'hC0 ("0"), or 8'hFF if BLANK_LZ=1; seg_ones=8'hC0.
  - busy=0, done=0, ovf=0.
  - Reset mid-conversion aborts it; no done pulse is produced.
- State IDLE:
  - Start condition: (value != last_conv) OR conv_req OR pending.
  - On the start edge E0: operand<=value; last_conv<=value; quot<=0; rem<=0; bitcnt<=6; pending<=0; busy<=1; go to DIV.
  - If no start condition holds, stay in IDLE; outputs hold.
- State DIV (exactly 7 edges, E1..E7), one operand bit per edge, MSB first:
  - r = {rem[3:0], operand[bitcnt]} (5 bits).
  - If r >= 10: rem <= r - 10 and quotient bit = 1; otherwise rem <= r and quotient bit = 0.
  - quot <= {quot[5:0], qbit}.
  - Decrement bitcnt; at E7 (bitcnt was 0) go to WRITE.
  - rem is always < 10, so 4 bits suffice; quot is 7 bits, max 12.
- State WRITE, committed at edge E8:
  - If operand > OVF_LIMIT: seg_tens=seg_ones=8'hBF ("-"), ovf=1.
  - Else: seg_tens = decode(quot[3:0]), with blank if BLANK_LZ and quot==0; seg_ones = decode(rem); ovf=0.
  - done=1 for exactly this one cycle (deasserts at E9); busy=0; go to IDLE.
- Latency: from the start edge to committed outputs is 8 edges. Back-to-back conversions start every 9 edges.
- Decode table (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - Any other code (unreachable) = FF.
- Boundary conditions:
  - value changes while busy: ignored until IDLE. The IDLE compare against last_conv then picks up the latest value; intermediate values are dropped.
  - conv_req while busy: sets pending; one extra conversion runs after the current one. Multiple requests collapse into one.
  - conv_req on the same edge as a value change in IDLE: a single conversion starts.
  - value equal to last_conv and no request: no conversion, no done pulse.
  - value changes during the WRITE cycle: handled at the next IDLE edge.
- Outputs are stable between done pulses; no partial digit update is ever visible.

Test Plan:
- Release reset with value=0, then idle 20 cycles -> seg_tens=C0, seg_ones=C0, busy=0, no done pulse.
- value 0->57 -> busy high for 8 edges; done at E8; seg_tens=92, seg_ones=F8, ovf=0.
- value=100, then 127 after done -> both digits BF, ovf=1; then value=99 -> 90/90, ovf=0.
- BLANK_LZ=1, value=7 -> seg_tens=FF, seg_ones=F8; value=0 -> FF/C0.
- value 12 and, 3 cycles later, 34 then 56 during busy -> first done shows F9/A4; second conversion shows 92/82; exactly two done pulses.
- conv_req pulsed twice during busy with value stable at 42 -> exactly one extra conversion, outputs 99/A4. Assert rst at E4 of the next conversion -> outputs C0/C0, busy=0, no done.
